shifter_seq_ctrl: RTL and testbench

//  Sequencer for a parallel-load shift register. Accepts SHIFT_WIDTH-bit words over a valid/ready handshake.

---
 rtl/shifter_seq_ctrl_pkg.sv | 26 ++
 rtl/shifter_seq_ctrl_if.sv | 37 +++
 rtl/shifter_seq_ctrl_shift_reg_core.sv | 57 +++++
 rtl/shifter_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_shifter_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shifter_seq_pkg
//   Shared types and helpers for the shifter sequencer slice.
//   - state_e   : controller states (IDLE, SHIFT, PARITY, GAP)
//   - DIR_LEFT  : shift left, MSB leaves first
//   - DIR_RIGHT : shift right, LSB leaves first
//   - cnt_width : width of a counter that must hold 0..width inclusive
// ---------------------------------------------------------------------------
package shifter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;

  // Bits needed to count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shifter_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// shifter_seq_ctrl_if
//   Word-in / bit-out handshake bundle for shifter_seq_ctrl.
//   Word side : in_valid, in_ready, in_data[SHIFT_WIDTH-1:0]
//   Bit side  : serial_ready, serial_valid, serial_out
//   master modport = producer/consumer environment, slave = the controller.
// ---------------------------------------------------------------------------
interface shifter_seq_ctrl_if #(
  parameter int SHIFT_WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [SHIFT_WIDTH-1:0] in_data;
  logic                   serial_ready;
  logic                   serial_valid;
  logic                   serial_out;

  modport master (
    output in_valid,
    output in_data,
    output serial_ready,
    input  in_ready,
    input  serial_valid,
    input  serial_out
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  serial_ready,
    output in_ready,
    output serial_valid,
    output serial_out
  );

endinterface

// File: rtl/shifter_seq_ctrl_shift_reg_core.sv
// ---------------------------------------------------------------------------
// shift_reg_core
//   Parallel-load shift register with enable and synchronous clear.
//   Ports: clk, rst_n (async active-low), sclr (sync clear, highest priority),
//          load/load_data (parallel load), enable (shift one bit),
//          shiftin (fill bit), q (register image), shiftout (bit leaving next).
//   DIRECTION = DIR_LEFT shifts toward the MSB; DIR_RIGHT toward the LSB.
// ---------------------------------------------------------------------------
module shift_reg_core
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIRECTION = DIR_LEFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             load,
  input  logic             enable,
  input  logic             shiftin,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             shiftout
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shifted_s;

  // Register image after a single shift in the configured direction
  always_comb begin
    shifted_s = q_r;
    if (DIRECTION == DIR_LEFT) begin
      shifted_s = {q_r[WIDTH-2:0], shiftin};
    end else begin
      shifted_s = {shiftin, q_r[WIDTH-1:1]};
    end
  end

  // Storage: clear beats load, load beats shift, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (sclr) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= load_data;
    end else if (enable) begin
      q_r <= shifted_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign q        = q_r;
  assign shiftout = (DIRECTION == DIR_LEFT) ? q_r[WIDTH-1] : q_r[0];

endmodule

// File: rtl/shifter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shifter_seq_ctrl
//   Takes SHIFT_WIDTH-bit words over a valid/ready handshake, serialises each
//   one bit per accepted cycle (serial_ready acts as shift enable, so stalls of
//   any length hold the current bit), then idles GAP_CYCLES clocks before the
//   next word is accepted.
//   Ports:
//     clock, aclr_n (async active-low reset), sclr (sync abort to IDLE)
//     bus          : shifter_seq_ctrl_if.slave (in_* word side, serial_* bit side)
//     frame_done   : pulse on the cycle the last bit of a frame is accepted
//     busy         : controller is not in IDLE
//     bit_cnt      : data bits accepted in the current frame
//   Build option: define SHIFTER_SEQ_PARITY_EN to append an even-parity bit
//   (XOR of the loaded word) after the data bits; frame_done then marks the
//   parity bit instead of the last data bit.
// ---------------------------------------------------------------------------
module shifter_seq_ctrl
  import shifter_seq_pkg::*;
#(
  parameter int SHIFT_WIDTH     = 8,
  parameter int SHIFT_DIRECTION = DIR_LEFT,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                                clock,
  input  logic                                aclr_n,
  input  logic                                sclr,
  shifter_seq_ctrl_if.slave                   bus,
  output logic                                frame_done,
  output logic                                busy,
  output logic [cnt_width(SHIFT_WIDTH)-1:0]   bit_cnt
);

  localparam int               CW         = cnt_width(SHIFT_WIDTH);
  localparam logic [CW-1:0]    LAST_BIT   = CW'(SHIFT_WIDTH - 1);
  localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYCLES - 1);
  // Where a finished frame goes: straight back to IDLE when no gap is wanted.
  localparam state_e           POST_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_e           state_r;
  state_e           state_s;
  logic             rdy_en_r;
  logic [CW-1:0]    cnt_r;
  logic [7:0]       gap_cnt_r;

  logic             in_ready_s;
  logic             handshake_s;
  logic             load_s;
  logic             shift_en_s;
  logic             frame_done_s;
  logic             serial_valid_s;
  logic             serial_bit_s;
  logic             shiftout_s;
  logic [SHIFT_WIDTH-1:0] q_unused_s;

`ifdef SHIFTER_SEQ_PARITY_EN
  logic             parity_r;

  // Even parity of a word: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [SHIFT_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // rdy_en keeps in_ready low until the first edge after reset release.
  assign in_ready_s  = rdy_en_r & (state_r == ST_IDLE) & ~sclr;
  assign handshake_s = bus.in_valid & in_ready_s;

  // Next state and per-cycle controls; sclr overrides every transition
  always_comb begin
    state_s        = state_r;
    load_s         = 1'b0;
    shift_en_s     = 1'b0;
    frame_done_s   = 1'b0;
    serial_valid_s = 1'b0;
    serial_bit_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          load_s  = 1'b1;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        serial_valid_s = 1'b1;
        serial_bit_s   = shiftout_s;
        if (bus.serial_ready) begin
          shift_en_s = 1'b1;
          if (cnt_r == LAST_BIT) begin
`ifdef SHIFTER_SEQ_PARITY_EN
            state_s = ST_PARITY;
`else
            frame_done_s = 1'b1;
            state_s      = POST_FRAME;
`endif
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end

      ST_PARITY: begin
`ifdef SHIFTER_SEQ_PARITY_EN
        serial_valid_s = 1'b1;
        serial_bit_s   = parity_r;
        if (bus.serial_ready) begin
          frame_done_s = 1'b1;
          state_s      = POST_FRAME;
        end else begin
          state_s = ST_PARITY;
        end
`else
        state_s = ST_IDLE;
`endif
      end

      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Abort: outputs still reflect the current state, but nothing advances.
    if (sclr) begin
      state_s      = ST_IDLE;
      load_s       = 1'b0;
      shift_en_s   = 1'b0;
      frame_done_s = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, ready enable, bit counter and gap counter registers
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_r   <= ST_IDLE;
      rdy_en_r  <= 1'b0;
      cnt_r     <= '0;
      gap_cnt_r <= 8'd0;
    end else begin
      state_r  <= state_s;
      rdy_en_r <= 1'b1;

      if (sclr || load_s) begin
        cnt_r <= '0;
      end else if (shift_en_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      // Counts clocks spent in GAP; zero whenever GAP is not continuing.
      if (!sclr && (state_r == ST_GAP) && (state_s == ST_GAP)) begin
        gap_cnt_r <= gap_cnt_r + 8'd1;
      end else begin
        gap_cnt_r <= 8'd0;
      end
    end
  end

`ifdef SHIFTER_SEQ_PARITY_EN
  // Parity of the word captured at load time, sent after the data bits
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      parity_r <= 1'b0;
    end else if (sclr) begin
      parity_r <= 1'b0;
    end else if (load_s) begin
      parity_r <= even_parity(bus.in_data);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Only the outgoing bit is consumed; the full register image is not needed.
  shift_reg_core #(
    .WIDTH     (SHIFT_WIDTH),
    .DIRECTION (SHIFT_DIRECTION)
  ) u_core (
    .clk       (clock),
    .rst_n     (aclr_n),
    .sclr      (sclr),
    .load      (load_s),
    .enable    (shift_en_s),
    .shiftin   (1'b0),
    .load_data (bus.in_data),
    .q         (q_unused_s),
    .shiftout  (shiftout_s)
  );

  assign bus.in_ready     = in_ready_s;
  assign bus.serial_valid = serial_valid_s;
  assign bus.serial_out   = serial_bit_s;
  assign frame_done       = frame_done_s;
  assign busy             = (state_r != ST_IDLE);
  assign bit_cnt          = cnt_r;

endmodule

// File: tb/tb_shifter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shifter_seq_ctrl
//   Directed bench for shifter_seq_ctrl (W=8, GAP_CYCLES=1). dut0 shifts MSB
//   first and is tracked every cycle by a frame-level model; dut1 shifts LSB
//   first on the same stimulus and is checked with literal expectations.
//   Honours SHIFTER_SEQ_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_shifter_seq_ctrl;

  localparam int W   = 8;
  localparam int GAP = 1;
`ifdef SHIFTER_SEQ_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic       clock = 1'b0;
  logic       aclr_n;
  logic       sclr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       serial_ready;

  logic       frame_done0, frame_done1, busy0, busy1;
  logic [3:0] bit_cnt0, bit_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  shifter_seq_ctrl_if #(.SHIFT_WIDTH(W)) bus0 ();
  shifter_seq_ctrl_if #(.SHIFT_WIDTH(W)) bus1 ();

  assign bus0.in_valid     = in_valid;
  assign bus0.in_data      = in_data;
  assign bus0.serial_ready = serial_ready;
  assign bus1.in_valid     = in_valid;
  assign bus1.in_data      = in_data;
  assign bus1.serial_ready = serial_ready;

  shifter_seq_ctrl #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION(0), .GAP_CYCLES(GAP)) dut0 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .bus(bus0),
    .frame_done(frame_done0), .busy(busy0), .bit_cnt(bit_cnt0));

  shifter_seq_ctrl #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION(1), .GAP_CYCLES(GAP)) dut1 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .bus(bus1),
    .frame_done(frame_done1), .busy(busy1), .bit_cnt(bit_cnt1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model of dut0 ----------------
  // A frame is the list of bits to transmit; m_pos is how many were taken.
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    logic [9:0] b;
    b = 10'd0;
    for (int i = 0; i < 8; i++) b[i] = d[7-i];
    b[8] = ^d;
    return b;
  endfunction

  logic [9:0] m_seq = 10'd0;
  int         m_len = 0;
  int         m_pos = 0;
  int         m_gap = 0;
  logic       m_rdy = 1'b0;
  logic       m_active, m_idle;

  assign m_active = (m_pos < m_len);
  assign m_idle   = !m_active && (m_gap == 0);

  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      m_rdy <= 1'b0; m_len <= 0; m_pos <= 0; m_gap <= 0; m_seq <= 10'd0;
    end else begin
      m_rdy <= 1'b1;
      if (sclr) begin
        m_len <= 0; m_pos <= 0; m_gap <= 0;
      end else if (m_idle && m_rdy && in_valid) begin
        m_seq <= frame_bits(in_data); m_len <= FRAME_LEN; m_pos <= 0;
      end else if (m_active && serial_ready) begin
        m_pos <= m_pos + 1;
        if (m_pos == m_len - 1) m_gap <= GAP;
      end else if (m_gap > 0) begin
        m_gap <= m_gap - 1;
      end
    end
  end

  // Every-cycle comparison of dut0 against the model, mid-cycle
  always @(negedge clock) begin
    check("in_ready",     32'(bus0.in_ready),     32'(m_rdy & m_idle & ~sclr));
    check("serial_valid", 32'(bus0.serial_valid), 32'(m_active));
    check("serial_out",   32'(bus0.serial_out),   32'(m_active ? m_seq[m_pos] : 1'b0));
    check("frame_done",   32'(frame_done0),
          32'(m_active & serial_ready & ~sclr & (m_pos == m_len - 1)));
    check("busy",         32'(busy0),             32'(!m_idle));
    check("bit_cnt",      32'(bit_cnt0),          32'((m_pos > W) ? W : m_pos));
  end

  // ---------------- stimulus helpers ----------------
  logic       so0 [1:16];
  logic       sv0 [1:16];
  logic       fd0 [1:16];
  logic       ir0 [1:16];
  logic [3:0] bc0 [1:16];
  logic       so1 [1:16];
  logic [3:0] bc1 [1:16];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait until dut0 offers in_ready; leaves time at a negedge.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    serial_ready = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if (bus0.in_ready) ok = 1'b1;
      else step();
    end
    if (!ok) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // Hand a word over, then record n cycles; index k = cycles after handshake.
  task automatic run_frame(input logic [7:0] d, input int n);
    in_data = d; in_valid = 1'b1; serial_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      so0[k] = bus0.serial_out; sv0[k] = bus0.serial_valid; fd0[k] = frame_done0;
      ir0[k] = bus0.in_ready;   bc0[k] = bit_cnt0;
      so1[k] = bus1.serial_out; bc1[k] = bit_cnt1;
      step();
    end
  endtask

  logic [7:0] d;
  int         fd_cyc;

  initial begin
    aclr_n = 1'b0; sclr = 1'b0; in_valid = 1'b0; in_data = 8'h00; serial_ready = 1'b0;
    repeat (2) step();
    check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    check("rst_busy",     32'(busy0),         32'd0);

    // Release: ready only after the first edge that sees aclr_n high
    aclr_n = 1'b1;
    #2;
    check("ready_before_edge", 32'(bus0.in_ready), 32'd0);
    step();
    check("ready_after_edge",  32'(bus0.in_ready), 32'd1);

    // Basic frame, both directions
    wait_idle();
    d = 8'b10001000;
    fd_cyc = FRAME_LEN;
    run_frame(d, 12);
    for (int k = 1; k <= 8; k++) begin
      check("msb_first_bit", 32'(so0[k]), 32'(d[8-k]));
      check("lsb_first_bit", 32'(so1[k]), 32'(d[k-1]));
    end
    for (int k = 1; k <= 12; k++) check("frame_done_cycle", 32'(fd0[k]), 32'(k == fd_cyc));
    check("bit_cnt_first", 32'(bc0[1]), 32'd0);
    check("gap_not_ready", 32'(ir0[fd_cyc+1]), 32'd0);
    check("ready_after_gap", 32'(ir0[fd_cyc+2]), 32'd1);
    check("lsb_bit_cnt_final", 32'(bc1[9]), 32'd8);

    // Parity / frame length with 8'hA7 (five ones -> parity 1)
    wait_idle();
    run_frame(8'hA7, 12);
`ifdef SHIFTER_SEQ_PARITY_EN
    check("a7_bit9_valid", 32'(sv0[9]), 32'd1);
    check("a7_bit9_value", 32'(so0[9]), 32'd1);
    check("a7_done_bit9",  32'(fd0[9]), 32'd1);
    check("a7_no_done_8",  32'(fd0[8]), 32'd0);
`else
    check("a7_bit9_idle",  32'(sv0[9]), 32'd0);
    check("a7_done_bit8",  32'(fd0[8]), 32'd1);
    check("a7_no_done_9",  32'(fd0[9]), 32'd0);
`endif

    // Stall after three accepted bits
    wait_idle();
    in_data = 8'b10110010; in_valid = 1'b1; serial_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    serial_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("stall_bit_held", 32'(bus0.serial_out), 32'd1);
      check("stall_cnt_held", 32'(bit_cnt0), 32'd3);
      step();
    end
    serial_ready = 1'b1;
    @(negedge clock);
    check("resume_bit4", 32'(bus0.serial_out), 32'd1);
    step();
    @(negedge clock);
    check("resume_bit5", 32'(bus0.serial_out), 32'd0);
    check("resume_cnt",  32'(bit_cnt0), 32'd4);

    // Synchronous abort with a word waiting
    wait_idle();
    in_data = 8'h5C; in_valid = 1'b1; serial_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    sclr = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clock);
    check("sclr_cnt_before", 32'(bit_cnt0), 32'd5);
    check("sclr_blocks_ready", 32'(bus0.in_ready), 32'd0);
    check("sclr_no_done", 32'(frame_done0), 32'd0);
    step();
    sclr = 1'b0;
    @(negedge clock);
    check("abort_idle",  32'(busy0), 32'd0);
    check("abort_valid", 32'(bus0.serial_valid), 32'd0);
    check("abort_cnt",   32'(bit_cnt0), 32'd0);
    check("abort_ready", 32'(bus0.in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("reload_busy", 32'(busy0), 32'd1);
    check("reload_bit",  32'(bus0.serial_out), 32'd0);

    // Asynchronous reset mid-frame
    wait_idle();
    in_data = 8'hFF; in_valid = 1'b1; serial_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    #2;
    aclr_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus0.in_ready), 32'd0);
    check("arst_valid",    32'(bus0.serial_valid), 32'd0);
    check("arst_out",      32'(bus0.serial_out), 32'd0);
    check("arst_done",     32'(frame_done0), 32'd0);
    check("arst_busy",     32'(busy0), 32'd0);
    check("arst_cnt",      32'(bit_cnt0), 32'd0);
    step(); step();
    aclr_n = 1'b1; in_valid = 1'b1; in_data = 8'h81;
    #1;
    check("arst_release_ready", 32'(bus0.in_ready), 32'd0);
    step();
    check("arst_first_edge_ready", 32'(bus0.in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
